// File: rtl/attention_av_stream_driver.sv
// Stream front-end for attention_av_multiply: loads precision codes, A and V from a
// word stream, starts the multiplier, captures Z and streams it back out one element at a time.
module attention_av_stream_driver #(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int N          = 1,
    parameter int E          = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           mul_start,
    output logic [DATA_WIDTH*L*N*L-1:0]    A_out,
    output logic [DATA_WIDTH*L*N*E-1:0]    V_out,
    output logic [3:0]                     tok_prec [L],
    input  logic                           mul_done,
    input  logic                           mul_out_valid,
    input  logic [DATA_WIDTH*L*N*E-1:0]    Z_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
    output logic                           busy
);

    localparam int unsigned N_PREC = L;
    localparam int unsigned N_A    = L * N * L;
    localparam int unsigned N_V    = L * N * E;
    localparam int unsigned N_Z    = L * N * E;
    localparam int unsigned MAX_AV = (N_A > N_V) ? N_A : N_V;
    localparam int unsigned MAXC   = (MAX_AV > N_PREC) ? MAX_AV : N_PREC;
    localparam int unsigned IDXW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREC,
        S_LOAD_A,
        S_LOAD_V,
        S_START,
        S_WAIT,
        S_STREAM
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [IDXW-1:0]               r_idx;
    logic [DATA_WIDTH*N_A-1:0]     r_a;
    logic [DATA_WIDTH*N_V-1:0]     r_v;
    logic [DATA_WIDTH*N_Z-1:0]     r_z;
    logic [3:0]                    r_tok [L];
    logic                          w_in_fire;
    logic                          w_out_fire;
    logic                          w_capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        mul_start = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_PREC;
            S_PREC: begin
                in_ready = 1'b1;
                if (in_valid && r_idx == IDXW'(N_PREC - 1)) w_next = S_LOAD_A;
            end
            S_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && r_idx == IDXW'(N_A - 1)) w_next = S_LOAD_V;
            end
            S_LOAD_V: begin
                in_ready = 1'b1;
                if (in_valid && r_idx == IDXW'(N_V - 1)) w_next = S_START;
            end
            S_START: begin
                mul_start = 1'b1;
                busy      = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (mul_done && mul_out_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_STREAM;
                end
            end
            S_STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && r_idx == IDXW'(N_Z - 1)) w_next = S_PREC;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Any state change clears idx, so the last word of a phase hands over with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_next != r_state) begin
            r_idx <= '0;
        end else if (w_in_fire || w_out_fire) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_v <= '0;
            r_z <= '0;
            for (int unsigned i = 0; i < N_PREC; i++) r_tok[i] <= '0;
        end else begin
            if (w_in_fire) begin
                case (r_state)
                    S_PREC: begin
                        for (int unsigned i = 0; i < N_PREC; i++)
                            if (r_idx == IDXW'(i)) r_tok[i] <= in_data[3:0];
                    end
                    S_LOAD_A: begin
                        for (int unsigned k = 0; k < N_A; k++)
                            if (r_idx == IDXW'(k)) r_a[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                    end
                    S_LOAD_V: begin
                        for (int unsigned k = 0; k < N_V; k++)
                            if (r_idx == IDXW'(k)) r_v[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                    end
                    default: ;
                endcase
            end
            if (w_capture) r_z <= Z_in;
        end
    end

    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        if (r_state == S_STREAM) begin
            out_last = (r_idx == IDXW'(N_Z - 1));
            for (int unsigned k = 0; k < N_Z; k++)
                if (r_idx == IDXW'(k)) out_data = r_z[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign A_out    = r_a;
    assign V_out    = r_v;
    assign tok_prec = r_tok;

endmodule

// File: tb/tb_attention_av_stream_driver.sv
// Directed/randomized bench for attention_av_stream_driver; the bench plays the multiplier
// and predicts every load and streamed Z element from its own arrays.
module tb_attention_av_stream_driver;

    localparam int DW = 16;
    localparam int L  = 8;
    localparam int N  = 1;
    localparam int E  = 8;
    localparam int NA = L * N * L;
    localparam int NV = L * N * E;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic              mul_start;
    logic [DW*NA-1:0]  A_out;
    logic [DW*NV-1:0]  V_out;
    logic [3:0]        tok_prec [L];
    logic              mul_done = 1'b0;
    logic              mul_out_valid = 1'b0;
    logic [DW*NV-1:0]  Z_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    logic [3:0]    m_prec [L];
    logic [DW-1:0] m_a [NA];
    logic [DW-1:0] m_v [NV];
    logic [DW-1:0] m_z [NV];

    attention_av_stream_driver #(
        .DATA_WIDTH(DW),
        .L(L),
        .N(N),
        .E(E)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .mul_start(mul_start),
        .A_out(A_out),
        .V_out(V_out),
        .tok_prec(tok_prec),
        .mul_done(mul_done),
        .mul_out_valid(mul_out_valid),
        .Z_in(Z_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mul_start === 1'b1) starts++;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: random, 1: counting pattern, 2: identity A with V[k]=k
    task automatic gen(input int mode);
        for (int i = 0; i < L; i++)
            m_prec[i] = (mode == 1) ? 4'd1 : (mode == 2) ? 4'd2 : 4'($urandom);
        for (int l = 0; l < L; l++)
            for (int l2 = 0; l2 < L; l2++)
                m_a[l*L + l2] = (mode == 1) ? DW'(l*L + l2) :
                                (mode == 2) ? ((l == l2) ? 16'h0001 : 16'h0000) : DW'($urandom);
        for (int k = 0; k < NV; k++)
            m_v[k] = (mode == 1) ? DW'(16'h0100 + k) : (mode == 2) ? DW'(k) : DW'($urandom);
        for (int l = 0; l < L; l++)
            for (int e = 0; e < E; e++) begin
                int unsigned acc = 0;
                for (int l2 = 0; l2 < L; l2++)
                    acc += int'(m_a[l*L + l2]) * int'(m_v[l2*E + e]);
                m_z[l*E + e] = DW'(acc);
            end
    endtask

    task automatic send(input logic [DW-1:0] w);
        int c = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && c < 50) begin
            tick();
            c++;
        end
        if (c >= 50) chk("send_timeout", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    task automatic load(input int gap);
        for (int i = 0; i < L; i++) begin
            send({12'($urandom), m_prec[i]});
            repeat (gap) tick();
        end
        for (int k = 0; k < NA; k++) begin
            send(m_a[k]);
            repeat (gap) tick();
        end
        for (int k = 0; k < NV; k++) begin
            send(m_v[k]);
            if (k != NV - 1) repeat (gap) tick();
        end
    endtask

    task automatic check_buses();
        for (int i = 0; i < L; i++) chk("tok_prec", tok_prec[i], m_prec[i]);
        for (int k = 0; k < NA; k++) chk("A_out", A_out[k*DW +: DW], m_a[k]);
        for (int k = 0; k < NV; k++) chk("V_out", V_out[k*DW +: DW], m_v[k]);
    endtask

    task automatic transfer(input int mode, input int gap, input int delay, input bit stray, input int stall_idx);
        int s0;
        logic [DW*NV-1:0] zp;
        logic [DW-1:0] exp;
        gen(mode);
        s0 = starts;
        load(gap);
        chk("start_pulse", mul_start, 1);
        chk("busy_start", busy, 1);
        chk("in_ready_start", in_ready, 0);
        tick();
        chk("start_once", mul_start, 0);
        chk("start_count", starts - s0, 1);
        for (int d = 0; d < delay; d++) begin
            if (stray) begin
                in_valid = 1'b1;
                in_data  = DW'($urandom);
            end
            mul_done = (d == 2);
            chk("wait_in_ready", in_ready, 0);
            chk("wait_busy", busy, 1);
            chk("wait_out_valid", out_valid, 0);
            tick();
            mul_done = 1'b0;
        end
        in_valid = 1'b0;
        chk("wait_hold", out_valid, 0);
        check_buses();
        if (mode == 1) chk("v63", V_out[63*DW +: DW], 16'h013F);
        for (int k = 0; k < NV; k++) zp[k*DW +: DW] = m_z[k];
        Z_in = zp;
        mul_done = 1'b1;
        mul_out_valid = 1'b1;
        tick();
        mul_done = 1'b0;
        mul_out_valid = 1'b0;
        for (int k = 0; k < NV; k++) zp[k*DW +: DW] = DW'($urandom);
        Z_in = zp;
        for (int k = 0; k < NV; k++) begin
            exp = (mode == 2) ? DW'(k) : m_z[k];
            if (k == stall_idx) begin
                out_ready = 1'b0;
                repeat (3) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, exp);
                    tick();
                end
            end else if ($urandom_range(3) == 0) begin
                out_ready = 1'b0;
                tick();
            end
            out_ready = 1'b1;
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, exp);
            chk("out_last", out_last, (k == NV - 1));
            tick();
            out_ready = 1'b0;
        end
        chk("post_in_ready", in_ready, 1);
        chk("post_out_valid", out_valid, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        chk("rel_in_ready", in_ready, 0);
        tick();
        chk("first_in_ready", in_ready, 1);

        // partial load, then async reset with idx=20 in LOAD_A
        gen(0);
        for (int i = 0; i < L; i++) send({12'($urandom), m_prec[i]});
        for (int k = 0; k < 20; k++) send(m_a[k]);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_in_ready", in_ready, 0);
        chk("mid_busy", busy, 0);
        chk("mid_start", mul_start, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_out_last", out_last, 0);
        chk("mid_out_data", out_data, 0);
        chk("mid_A_zero", {31'b0, |A_out}, 0);
        chk("mid_V_zero", {31'b0, |V_out}, 0);
        chk("mid_tok0", tok_prec[0], 0);
        tick();
        rst = 1'b0;
        chk("rel2_in_ready", in_ready, 0);
        tick();
        chk("rel2_in_ready_hi", in_ready, 1);

        transfer(1, 0, 0, 1'b0, -1);
        transfer(1, 1, 10, 1'b1, -1);
        transfer(0, 0, 3, 1'b0, 5);
        transfer(2, 0, 1, 1'b0, -1);
        for (int r = 0; r < 2; r++)
            transfer(0, int'($urandom_range(1)), int'($urandom_range(5)), 1'b1, int'($urandom_range(63)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
